// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl
//   Execute-stage conditional-execution controller. Holds the architectural
//   NZCV status register and evaluates each instruction's condition field
//   against it. The result gates the EX-stage write-enables, commits flag
//   updates and sequences the squash of younger instructions after a taken
//   branch.
//
//   Optional feature: define COND_STATS_EN to build the two 16-bit saturating
//   statistics counters. Without it, exec_count and annul_count read zero.
//
// Parameters
//   SQUASH_DEPTH  younger slots squashed after a taken branch (1..3)
//
// Ports
//   clk          in   core clock, rising edge
//   rst_n        in   synchronous active-low reset
//   valid_in     in   an instruction occupies EX this cycle
//   stall        in   pipeline freeze, holds all state
//   cond         in   [3:0] instruction condition field
//   s_bit        in   instruction requests a flag update
//   is_branch    in   instruction is B/BL
//   alu_nzcv     in   [3:0] ALU result flags {N,Z,C,V}
//   exec_en      out  instruction executes (combinational)
//   branch_taken out  executing branch redirects PC (combinational)
//   flush        out  registered squash of IF/ID contents
//   status       out  [3:0] registered {N,Z,C,V}
//   exec_count   out  [15:0] executed-instruction count
//   annul_count  out  [15:0] annulled/squashed-instruction count
module cond_exec_ctrl #(
    parameter int SQUASH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        stall,
    input  logic [3:0]  cond,
    input  logic        s_bit,
    input  logic        is_branch,
    input  logic [3:0]  alu_nzcv,
    output logic        exec_en,
    output logic        branch_taken,
    output logic        flush,
    output logic [3:0]  status,
    output logic [15:0] exec_count,
    output logic [15:0] annul_count
);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] squash_cnt;
    logic [1:0] next_cnt;
    logic [3:0] status_q;
    logic       flush_q;
    logic       pass;

    // Condition evaluation; f = {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = cy;
            4'h3:    r = !cy;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = cy & !z;
            4'h9:    r = !cy | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign pass = cond_pass(cond, status_q);

    // Next-state and combinational outputs. Nothing executes while reset is
    // asserted; a stall holds the FSM and the squash counter.
    always_comb begin
        next_state   = state;
        next_cnt     = squash_cnt;
        exec_en      = 1'b0;
        branch_taken = 1'b0;
        case (state)
            RUN: begin
                exec_en      = rst_n & valid_in & pass & !stall;
                branch_taken = exec_en & is_branch;
                if (branch_taken) begin
                    next_state = SQUASH;
                    next_cnt   = SQUASH_DEPTH[1:0];
                end
            end
            SQUASH: begin
                // Count reaching 1 marks the final squash cycle, so flush
                // stays high for exactly SQUASH_DEPTH non-stalled cycles.
                if (!stall) begin
                    if (squash_cnt <= 2'd1) begin
                        next_state = RUN;
                        next_cnt   = 2'd0;
                    end else begin
                        next_cnt = squash_cnt - 2'd1;
                    end
                end
            end
            default: begin
                next_state = RUN;
                next_cnt   = 2'd0;
            end
        endcase
    end

    // State, flush and status registers. Flags and a new squash may commit
    // on the same edge when a taken branch also sets S.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            squash_cnt <= 2'd0;
            flush_q    <= 1'b0;
            status_q   <= 4'b0000;
        end else begin
            state      <= next_state;
            squash_cnt <= next_cnt;
            flush_q    <= (next_state == SQUASH);
            if (exec_en && s_bit) begin
                status_q <= alu_nzcv;
            end
        end
    end

    assign flush  = flush_q;
    assign status = status_q;

`ifdef COND_STATS_EN
    logic        annul;
    logic [15:0] exec_cnt_q;
    logic [15:0] annul_cnt_q;

    // An instruction is annulled when it is present and not stalled but
    // either fails its condition or sits in a squashed slot.
    assign annul = rst_n & valid_in & !stall & (!pass | (state == SQUASH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exec_cnt_q  <= 16'h0000;
            annul_cnt_q <= 16'h0000;
        end else begin
            if (exec_en && (exec_cnt_q != 16'hFFFF)) begin
                exec_cnt_q <= exec_cnt_q + 16'd1;
            end
            if (annul && (annul_cnt_q != 16'hFFFF)) begin
                annul_cnt_q <= annul_cnt_q + 16'd1;
            end
        end
    end

    assign exec_count  = exec_cnt_q;
    assign annul_count = annul_cnt_q;
`else
    assign exec_count  = 16'h0000;
    assign annul_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
module tb_cond_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        stall;
    logic [3:0]  cond;
    logic        s_bit;
    logic        is_branch;
    logic [3:0]  alu_nzcv;
    logic        exec_en;
    logic        branch_taken;
    logic        flush;
    logic [3:0]  status;
    logic [15:0] exec_count;
    logic [15:0] annul_count;

    int checks   = 0;
    int failures = 0;

`ifdef COND_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    cond_exec_ctrl #(.SQUASH_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall),
        .cond(cond), .s_bit(s_bit), .is_branch(is_branch), .alu_nzcv(alu_nzcv),
        .exec_en(exec_en), .branch_taken(branch_taken), .flush(flush),
        .status(status), .exec_count(exec_count), .annul_count(annul_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic s,
                         input logic b, input logic [3:0] f);
        valid_in  = v;
        cond      = c;
        s_bit     = s;
        is_branch = b;
        alu_nzcv  = f;
        #1;
    endtask

    // Reference condition table, written from the ARM condition list.
    function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z == 1'b1;
            4'd1:  return z == 1'b0;
            4'd2:  return cy == 1'b1;
            4'd3:  return cy == 1'b0;
            4'd4:  return n == 1'b1;
            4'd5:  return n == 1'b0;
            4'd6:  return v == 1'b1;
            4'd7:  return v == 1'b0;
            4'd8:  return (cy == 1'b1) && (z == 1'b0);
            4'd9:  return (cy == 1'b0) || (z == 1'b1);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return (z == 1'b0) && (n == v);
            4'd13: return (z == 1'b1) || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        drive(1'b1, 4'hE, 1'b1, 1'b1, 4'b1111);

        // Reset: outputs quiet while rst_n low
        tick();
        tick();
        chk("rst_exec_en", {15'd0, exec_en}, 16'd0);
        chk("rst_branch_taken", {15'd0, branch_taken}, 16'd0);
        chk("rst_status", {12'd0, status}, 16'd0);
        chk("rst_flush", {15'd0, flush}, 16'd0);
        chk("rst_exec_count", exec_count, 16'd0);
        chk("rst_annul_count", annul_count, 16'd0);

        // AL with S, flags 0100
        rst_n = 1'b1;
        drive(1'b1, 4'hE, 1'b1, 1'b0, 4'b0100);
        chk("al_exec_en", {15'd0, exec_en}, 16'd1);
        tick();
        chk("al_status", {12'd0, status}, 16'h4);

        // EQ passes, NE fails
        drive(1'b1, 4'h0, 1'b0, 1'b0, 4'b0000);
        chk("eq_exec_en", {15'd0, exec_en}, 16'd1);
        tick();
        drive(1'b1, 4'h1, 1'b0, 1'b0, 4'b0000);
        chk("ne_exec_en", {15'd0, exec_en}, 16'd0);
        tick();
        chk("cnt_exec_after_ne", exec_count, STATS ? 16'd2 : 16'd0);
        chk("cnt_annul_after_ne", annul_count, STATS ? 16'd1 : 16'd0);
        chk("status_kept", {12'd0, status}, 16'h4);

        // Taken branch at t, squash t+1 and t+2, run again at t+3
        drive(1'b1, 4'hE, 1'b0, 1'b1, 4'b0000);
        chk("br_taken", {15'd0, branch_taken}, 16'd1);
        chk("br_exec_en", {15'd0, exec_en}, 16'd1);
        tick();
        drive(1'b1, 4'hE, 1'b0, 1'b0, 4'b0000);
        chk("sq1_flush", {15'd0, flush}, 16'd1);
        chk("sq1_exec_en", {15'd0, exec_en}, 16'd0);
        tick();
        drive(1'b1, 4'hE, 1'b0, 1'b1, 4'b0000);
        chk("sq2_flush", {15'd0, flush}, 16'd1);
        chk("sq2_exec_en", {15'd0, exec_en}, 16'd0);
        chk("sq2_branch_squashed", {15'd0, branch_taken}, 16'd0);
        tick();
        drive(1'b1, 4'hE, 1'b0, 1'b0, 4'b0000);
        chk("run_flush", {15'd0, flush}, 16'd0);
        chk("run_exec_en", {15'd0, exec_en}, 16'd1);

        // Branch with S: flags and squash on the same edge; stall mid-squash
        drive(1'b1, 4'hE, 1'b1, 1'b1, 4'b1001);
        chk("bs_taken", {15'd0, branch_taken}, 16'd1);
        tick();
        chk("bs_status", {12'd0, status}, 16'h9);
        chk("bs_flush", {15'd0, flush}, 16'd1);
        stall = 1'b1;
        drive(1'b1, 4'hE, 1'b1, 1'b0, 4'b0110);
        chk("stall_exec_en", {15'd0, exec_en}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_flush", {15'd0, flush}, 16'd1);
            chk("stall_status", {12'd0, status}, 16'h9);
        end
        stall = 1'b0;
        drive(1'b1, 4'hE, 1'b0, 1'b0, 4'b0000);
        chk("post_stall1_flush", {15'd0, flush}, 16'd1);
        chk("post_stall1_exec_en", {15'd0, exec_en}, 16'd0);
        tick();
        chk("post_stall2_flush", {15'd0, flush}, 16'd1);
        tick();
        chk("post_stall_end_flush", {15'd0, flush}, 16'd0);
        chk("post_stall_exec_en", {15'd0, exec_en}, 16'd1);

        // Reset mid-squash
        drive(1'b1, 4'hE, 1'b0, 1'b1, 4'b0000);
        tick();
        chk("pre_rst_flush", {15'd0, flush}, 16'd1);
        rst_n = 1'b0;
        drive(1'b1, 4'hE, 1'b0, 1'b0, 4'b0000);
        tick();
        chk("mid_rst_exec_en", {15'd0, exec_en}, 16'd0);
        chk("mid_rst_flush", {15'd0, flush}, 16'd0);
        chk("mid_rst_status", {12'd0, status}, 16'd0);
        chk("mid_rst_exec_count", exec_count, 16'd0);
        chk("mid_rst_annul_count", annul_count, 16'd0);
        rst_n = 1'b1;
        #1;
        chk("after_rst_exec_en", {15'd0, exec_en}, 16'd1);

        // Sweep all conditions against all flag values
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 4'hE, 1'b1, 1'b0, f[3:0]);
            tick();
            chk("sweep_status", {12'd0, status}, f[15:0]);
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, c[3:0], 1'b0, 1'b0, 4'b0000);
                chk($sformatf("sweep_c%0d_f%0d", c, f), {15'd0, exec_en},
                    {15'd0, exp_pass(c[3:0], f[3:0])});
            end
        end

`ifdef COND_STATS_EN
        // Saturation of the executed counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 4'hE, 1'b0, 1'b0, 4'b0000);
        repeat (65540) tick();
        chk("sat_exec_count", exec_count, 16'hFFFF);
        chk("sat_annul_count", annul_count, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_exec_ctrl.md
# cond_exec_ctrl

Execute-stage conditional-execution controller for the ARM core. It owns the architectural NZCV status register and evaluates each instruction's 4-bit condition field against it. From that result it gates the write-enables of the execute stage, commits flag updates, and sequences a two-cycle squash of younger instructions after a taken branch. It sits between the ID/EX pipeline register and the EX/MEM register and drives the IF/ID flush lines.

## Interface
Parameters:
- SQUASH_DEPTH, 2, number of younger pipeline slots squashed after a taken branch (legal range 1–3).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid_in  input  1  an instruction occupies EX this cycle.
- stall  input  1  pipeline freeze; holds all state.
- cond  input  4  instruction condition field.
- s_bit  input  1  instruction requests a flag update.
- is_branch  input  1  instruction is B/BL.
- alu_nzcv  input  4  ALU result flags {N,Z,C,V}.
- exec_en  output  1  instruction executes (gates WB, MEM write, flag write).
- branch_taken  output  1  executing branch redirects PC.
- flush  output  1  squash IF/ID contents.
- status  output  4  current registered {N,Z,C,V}.
- exec_count  output  16  executed-instruction count (Configuration).
- annul_count  output  16  annulled/squashed-instruction count (Configuration).

## Operation
- Condition pass, evaluated from registered status:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- FSM states: RUN, SQUASH.
  - RUN: exec_en = valid_in & pass & !stall; branch_taken = exec_en & is_branch.
  - branch_taken in RUN → SQUASH with squash_cnt = SQUASH_DEPTH.
- SQUASH:
  - exec_en = 0 and branch_taken = 0 regardless of inputs.
  - flush = 1.
  - Each non-stalled cycle decrements squash_cnt; the cycle it reaches 1 returns to RUN.
- Status write: status ← alu_nzcv at clock edge when exec_en & s_bit; otherwise held.
- Annulled instruction: valid_in & !stall & (!pass or state==SQUASH). No state change except the counter.
- stall = 1 freezes FSM, squash_cnt, status and counters; flush holds its current value.

## Timing
- exec_en and branch_taken: combinational, same cycle as inputs.
- status update: visible the cycle after the writing instruction. Back-to-back dependent conditions need no forwarding.
- flush: registered; rises the cycle after branch_taken and stays high for exactly SQUASH_DEPTH non-stalled cycles.
- A branch arriving in the last SQUASH cycle is squashed, not taken.
- Reset (rst_n = 0 at an edge): state RUN, squash_cnt 0, status 4'b0000, flush 0, counters 0.
  - Combinational outputs: exec_en 0 and branch_taken 0 while rst_n is low.
  - Reset mid-SQUASH aborts it; flush is 0 the following cycle.
- Simultaneous s_bit & is_branch on a taken instruction: flags commit and squash starts on the same edge.

## Configuration
- COND_STATS_EN defined: two 16-bit saturating counters.
  - exec_count increments on exec_en.
  - annul_count increments on every annulled instruction.
  - Both hold at 16'hFFFF and reset to 0.
- COND_STATS_EN undefined: no counter logic; exec_count and annul_count are tied to 16'h0000; all other behaviour is identical.

## Test plan
- Reset then AL instruction with s_bit, alu_nzcv=4'b0100 → exec_en=1 same cycle; status=4'b0100 next cycle.
- status=4'b0100, EQ then NE, no stall → exec_en 1 then 0; annul_count=1 with COND_STATS_EN.
- Taken AL branch at cycle t with valid_in held high → flush=1 for cycles t+1 and t+2 (SQUASH_DEPTH=2); exec_en=0 in both; exec_en=1 again at t+3.
- stall=1 for 3 cycles during SQUASH → flush stays 1 and squash_cnt frozen; SQUASH completes 2 non-stalled cycles later.
- rst_n low during SQUASH → next cycle flush=0, status=0, counters 0.
- Flag-boundary sweep: all 16 cond values × all 16 NZCV values, incl. LE with Z=1,N==V → pass=1 and GT with Z=1 → pass=0.
- Counter saturation (COND_STATS_EN): 65 540 executed instructions → exec_count=16'hFFFF.
